// File: rtl/udp_frame_scheduler_pkg.sv
// Shared types and constants for the UDP frame scheduler and its VRAM reader.
// Header and tail lengths describe the byte_data generator's fixed packet framing.
package udp_sched_pkg;

   typedef enum logic [2:0] {IDLE, START, ACK, RUN, GAP} state_t;

   localparam int HDR_BYTES   = 42;
   localparam int TAIL_CYCLES = 20;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/udp_vram_reader.sv
// Times VRAM reads against the generator: payload byte k is read RD_LAT cycles before it is consumed.
// Free-running once started; no backpressure, abort stops any pending reads.
module udp_vram_reader
   import udp_sched_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int ADDR_W = 22
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [14:0]       i_len,
   output logic              o_vram_en,
   output logic [ADDR_W-1:0] o_vram_addr
);

   // Counter value (cycles since the start edge) at which byte 0's read is registered.
   localparam logic [15:0] FIRST_CNT = 16'(HDR_BYTES - 1 - RD_LAT);

   logic [15:0]       r_cnt;
   logic              r_act;
   logic [ADDR_W-1:0] r_base;
   logic [14:0]       r_len;
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;

   logic [15:0]       w_off;
   logic              w_hit;
   logic              w_last;

   assign w_off  = r_cnt - FIRST_CNT;
   assign w_hit  = r_act && (r_cnt >= FIRST_CNT) && (w_off < {1'b0, r_len});
   assign w_last = w_hit && (w_off == ({1'b0, r_len} - 16'd1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_act  <= 1'b0;
         r_base <= '0;
         r_len  <= '0;
         r_en   <= 1'b0;
         r_addr <= '0;
      end else begin
         r_en   <= w_hit && !i_abort;
         r_addr <= (w_hit && !i_abort) ? (r_base + ADDR_W'(w_off)) : '0;
         if (r_act)
            r_cnt <= r_cnt + 16'd1;
         if (i_abort || w_last)
            r_act <= 1'b0;
         if (i_start) begin
            r_act  <= 1'b1;
            r_cnt  <= '0;
            r_base <= i_base;
            r_len  <= i_len;
         end
      end
   end

   assign o_vram_en   = r_en;
   assign o_vram_addr = r_addr;

endmodule

// File: rtl/udp_frame_scheduler.sv
// Walks one VRAM frame as rows x segments x clones, starting byte_data once per packet.
// Start-to-generator latency 1 cycle; paced by generator busy plus IFG_CYCLES, no other backpressure.
module udp_frame_scheduler
   import udp_sched_pkg::*;
#(
   parameter int H_BYTES    = 1920,
   parameter int V_ROWS     = 1080,
   parameter int SEG_BYTES  = 1440,
   parameter int CLONES     = 1,
   parameter int IFG_CYCLES = 12,
   parameter int RD_LAT     = 1,
   parameter int ADDR_W     = 22
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_start,
   input  logic              i_gen_busy,
   output logic              o_gen_start,
   output logic [14:0]       o_data_byte,
   output logic [7:0]        o_row_number,
   output logic [15:0]       o_segment_num,
   output logic [7:0]        o_index_clone,
   output logic              o_vram_en,
   output logic [ADDR_W-1:0] o_vram_addr,
   output logic              o_frame_busy,
   output logic              o_frame_done,
   output logic              o_overrun,
   output logic              o_gen_err
);

   localparam int          NSEG       = ceil_div(H_BYTES, SEG_BYTES);
   localparam logic [14:0] SEG_LEN    = 15'(SEG_BYTES);
   localparam logic [14:0] H_LEN      = 15'(H_BYTES);
   localparam logic [14:0] FIRST_LEN  = (SEG_LEN < H_LEN) ? SEG_LEN : H_LEN;
   localparam logic [15:0] LAST_SEG   = 16'(NSEG - 1);
   localparam logic [15:0] LAST_ROW   = 16'(V_ROWS - 1);
   localparam logic [7:0]  LAST_CLONE = 8'(CLONES - 1);
   localparam logic [15:0] LAST_GAP   = 16'(IFG_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_BYTES);

   state_t            r_state;
   logic [15:0]       r_row;
   logic [15:0]       r_seg;
   logic [7:0]        r_clone;
   logic [14:0]       r_seg_off;
   logic [14:0]       r_data_byte;
   logic [ADDR_W-1:0] r_row_base;
   logic [15:0]       r_gap_cnt;
   logic              r_ack_wait;
   logic              r_gen_start;
   logic              r_frame_busy;
   logic              r_frame_done;
   logic              r_overrun;
   logic              r_gen_err;

   logic [14:0]       w_next_off;
   logic [14:0]       w_next_rem;
   logic [14:0]       w_next_len;
   logic [ADDR_W-1:0] w_base;

   // Only consulted when another segment exists, so the offset never passes H_BYTES.
   assign w_next_off = r_seg_off + SEG_LEN;
   assign w_next_rem = H_LEN - w_next_off;
   assign w_next_len = (w_next_rem < SEG_LEN) ? w_next_rem : SEG_LEN;
   assign w_base     = r_row_base + ADDR_W'(r_seg_off);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_row        <= '0;
         r_seg        <= '0;
         r_clone      <= '0;
         r_seg_off    <= '0;
         r_data_byte  <= '0;
         r_row_base   <= '0;
         r_gap_cnt    <= '0;
         r_ack_wait   <= 1'b0;
         r_gen_start  <= 1'b0;
         r_frame_busy <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
         r_gen_err    <= 1'b0;
      end else begin
         r_gen_start  <= 1'b0;
         r_frame_done <= 1'b0;
         r_gen_err    <= 1'b0;
         r_overrun    <= i_frame_start && r_frame_busy;
         case (r_state)
            IDLE: begin
               // A start coinciding with the done pulse is dropped, not queued.
               if (i_frame_start && !r_frame_done) begin
                  r_row        <= '0;
                  r_seg        <= '0;
                  r_clone      <= '0;
                  r_seg_off    <= '0;
                  r_row_base   <= '0;
                  r_data_byte  <= FIRST_LEN;
                  r_frame_busy <= 1'b1;
                  r_gen_start  <= 1'b1;
                  r_state      <= START;
               end
            end
            START: begin
               r_ack_wait <= 1'b0;
               r_state    <= ACK;
            end
            ACK: begin
               if (i_gen_busy) begin
                  r_state <= RUN;
               end else if (r_ack_wait) begin
                  r_gen_err    <= 1'b1;
                  r_frame_busy <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_ack_wait <= 1'b1;
               end
            end
            RUN: begin
               if (!i_gen_busy) begin
                  r_gap_cnt <= '0;
                  r_state   <= GAP;
               end
            end
            GAP: begin
               if (r_gap_cnt != LAST_GAP) begin
                  r_gap_cnt <= r_gap_cnt + 16'd1;
               end else if (r_clone != LAST_CLONE) begin
                  r_clone     <= r_clone + 8'd1;
                  r_gen_start <= 1'b1;
                  r_state     <= START;
               end else if (r_seg != LAST_SEG) begin
                  r_clone     <= '0;
                  r_seg       <= r_seg + 16'd1;
                  r_seg_off   <= w_next_off;
                  r_data_byte <= w_next_len;
                  r_gen_start <= 1'b1;
                  r_state     <= START;
               end else if (r_row != LAST_ROW) begin
                  r_clone     <= '0;
                  r_seg       <= '0;
                  r_seg_off   <= '0;
                  r_data_byte <= FIRST_LEN;
                  r_row       <= r_row + 16'd1;
                  r_row_base  <= r_row_base + ROW_STEP;
                  r_gen_start <= 1'b1;
                  r_state     <= START;
               end else begin
                  r_frame_done <= 1'b1;
                  r_frame_busy <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   udp_vram_reader #(
      .RD_LAT (RD_LAT),
      .ADDR_W (ADDR_W)
   ) u_reader (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (r_gen_start),
      .i_abort     (r_gen_err),
      .i_base      (w_base),
      .i_len       (r_data_byte),
      .o_vram_en   (o_vram_en),
      .o_vram_addr (o_vram_addr)
   );

   assign o_gen_start   = r_gen_start;
   assign o_data_byte   = r_data_byte;
   assign o_row_number  = r_row[7:0];
   assign o_segment_num = r_seg;
   assign o_index_clone = r_clone;
   assign o_frame_busy  = r_frame_busy;
   assign o_frame_done  = r_frame_done;
   assign o_overrun     = r_overrun;
   assign o_gen_err     = r_gen_err;

endmodule

// File: tb/tb_udp_frame_scheduler.sv
// Scoreboarded bench: 100-byte rows, 40-byte segments, 2 rows, 2 clones, with byte_data and VRAM models.
module tb_udp_frame_scheduler;
   import udp_sched_pkg::*;

   localparam int H   = 100;
   localparam int V   = 2;
   localparam int SEG = 40;
   localparam int CL  = 2;
   localparam int IFG = 12;
   localparam int RDL = 1;
   localparam int AW  = 22;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          gen_busy = 1'b0;
   logic          o_gen_start;
   logic [14:0]   o_data_byte;
   logic [7:0]    o_row_number;
   logic [15:0]   o_segment_num;
   logic [7:0]    o_index_clone;
   logic          o_vram_en;
   logic [AW-1:0] o_vram_addr;
   logic          o_frame_busy;
   logic          o_frame_done;
   logic          o_overrun;
   logic          o_gen_err;

   udp_frame_scheduler #(
      .H_BYTES(H), .V_ROWS(V), .SEG_BYTES(SEG), .CLONES(CL),
      .IFG_CYCLES(IFG), .RD_LAT(RDL), .ADDR_W(AW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start), .i_gen_busy(gen_busy),
      .o_gen_start(o_gen_start), .o_data_byte(o_data_byte), .o_row_number(o_row_number),
      .o_segment_num(o_segment_num), .o_index_clone(o_index_clone), .o_vram_en(o_vram_en),
      .o_vram_addr(o_vram_addr), .o_frame_busy(o_frame_busy), .o_frame_done(o_frame_done),
      .o_overrun(o_overrun), .o_gen_err(o_gen_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int row;
      int seg;
      int clone;
   } pkt_t;

   pkt_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // byte_data model: busy rises after the start edge E0, payload byte k taken at E(43+k),
   // busy falls after E(21+42+len). VRAM model returns addr[7:0] one cycle after the read.
   bit         m_dead = 1'b0;
   int         m_cnt = 0;
   int         m_len = 0;
   int         cap_n = 0;
   logic [7:0] cap [0:255];
   logic [7:0] vram_q = 8'd0;

   always @(posedge clk) begin
      if (o_vram_en)
         vram_q <= o_vram_addr[7:0];
   end

   always @(posedge clk) begin
      if (rst) begin
         gen_busy <= 1'b0;
         m_cnt    <= 0;
         cap_n    <= 0;
      end else if (o_gen_start && !m_dead) begin
         gen_busy <= 1'b1;
         m_cnt    <= 0;
         m_len    <= int'(o_data_byte);
         cap_n    <= 0;
      end else if (gen_busy) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt >= HDR_BYTES && (m_cnt - HDR_BYTES) < m_len) begin
            cap[8'(m_cnt - HDR_BYTES)] <= vram_q;
            cap_n <= cap_n + 1;
         end
         if (m_cnt == HDR_BYTES + TAIL_CYCLES + m_len)
            gen_busy <= 1'b0;
      end
   end

   // Monitor: tcnt = edges since E0, so a value visible at tcnt=j is sampled at E(j+1).
   int   tcnt = 0;
   int   en_cnt = 0;
   int   en_first = -1;
   int   en_last = -1;
   int   gap_cnt = 0;
   int   n_starts = 0;
   int   n_done = 0;
   int   n_ovr = 0;
   int   n_gerr = 0;
   int   tot_en = 0;
   logic prev_busy = 1'b0;
   logic pkt_act = 1'b0;
   logic gap_meas = 1'b0;
   pkt_t cur;

   always @(negedge clk) begin
      if (rst) begin
         pkt_act   = 1'b0;
         gap_meas  = 1'b0;
         prev_busy = 1'b0;
      end else begin
         tcnt = tcnt + 1;
         if (o_gen_start) begin
            n_starts++;
            if (gap_meas)
               chk("gap_busy_low_to_start", gap_cnt, IFG + 1);
            gap_meas = 1'b0;
            chk("start_was_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               chk("data_byte", int'(o_data_byte), cur.len);
               chk("row_number", int'(o_row_number), cur.row);
               chk("segment_num", int'(o_segment_num), cur.seg);
               chk("index_clone", int'(o_index_clone), cur.clone);
               pkt_act = 1'b1;
            end
            tcnt     = -1;
            en_cnt   = 0;
            en_first = -1;
            en_last  = -1;
         end
         if (o_vram_en) begin
            tot_en++;
            if (pkt_act) begin
               en_cnt++;
               if (en_first < 0) en_first = tcnt;
               en_last = tcnt;
            end
         end
         if (prev_busy && !gen_busy && pkt_act) begin
            int bad;
            int base;
            bad  = 0;
            base = cur.row * H + cur.seg * SEG;
            for (int k = 0; k < cur.len; k++)
               if (cap[8'(k)] != 8'(base + k)) bad++;
            chk("vram_en_cycles", en_cnt, cur.len);
            chk("vram_first_edge", en_first + 1, 42);
            chk("vram_last_edge", en_last + 1, 41 + cur.len);
            chk("payload_bytes_wrong", bad, 0);
            chk("payload_len", cap_n, cur.len);
            pkt_act  = 1'b0;
            gap_meas = 1'b1;
            gap_cnt  = 0;
         end
         if (gap_meas && !gen_busy)
            gap_cnt++;
         if (o_frame_done) begin
            n_done++;
            gap_meas = 1'b0;
         end
         if (o_overrun)
            n_ovr++;
         if (o_gen_err) begin
            n_gerr++;
            chk("gen_err_delay", tcnt, 2);
            pkt_act = 1'b0;
         end
         prev_busy = gen_busy;
      end
   end

   task automatic push_frame();
      int lens [3];
      lens = '{40, 40, 20};
      for (int r = 0; r < V; r++)
         for (int s = 0; s < 3; s++)
            for (int c = 0; c < CL; c++)
               exp_q.push_back('{lens[s], r, s, c});
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (o_frame_done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   function automatic int any_out();
      return int'(|{o_gen_start, o_data_byte, o_row_number, o_segment_num, o_index_clone,
                    o_vram_en, o_vram_addr, o_frame_busy, o_frame_done, o_overrun, o_gen_err});
   endfunction

   initial begin
      bit seen;
      int s0, d0, o0, e0, en0;
      rst = 1'b1;
      frame_start = 1'b0;
      if (H * V > (1 << AW)) begin
         $display("FAIL addr_width: H*V=%0d exceeds 2**%0d", H * V, AW);
         $fatal(1);
      end
      repeat (3) @(negedge clk);
      #1 chk("reset_outputs", any_out(), 0);
      rst = 1'b0;
      @(negedge clk);

      // Full frame: descriptors, payload, VRAM timing and inter-packet gap.
      s0 = n_starts; d0 = n_done; o0 = n_ovr;
      push_frame();
      pulse_start();
      #1 chk("frame_busy_after_start", int'(o_frame_busy), 1);
      wait_done(seen);
      chk("frame1_done_seen", int'(seen), 1);
      frame_start = 1'b1;            // coincides with the done pulse: must be dropped
      @(negedge clk);
      frame_start = 1'b0;
      #1 chk("busy_low_after_done", int'(o_frame_busy), 0);
      repeat (20) @(negedge clk);
      #1;
      chk("frame1_starts", n_starts - s0, 12);
      chk("frame1_done_count", n_done - d0, 1);
      chk("frame1_queue_left", exp_q.size(), 0);
      chk("frame1_no_overrun", n_ovr - o0, 0);
      chk("start_on_done_ignored", int'(o_frame_busy), 0);

      // Overrun: restart pulse mid-frame is ignored.
      s0 = n_starts; d0 = n_done; o0 = n_ovr;
      push_frame();
      pulse_start();
      repeat (300) @(negedge clk);
      pulse_start();
      wait_done(seen);
      chk("frame2_done_seen", int'(seen), 1);
      repeat (20) @(negedge clk);
      #1;
      chk("overrun_pulses", n_ovr - o0, 1);
      chk("frame2_starts", n_starts - s0, 12);
      chk("frame2_done_count", n_done - d0, 1);
      chk("frame2_queue_left", exp_q.size(), 0);

      // Generator never acknowledges.
      m_dead = 1'b1;
      e0 = n_gerr; d0 = n_done; en0 = tot_en;
      exp_q.push_back('{40, 0, 0, 0});
      pulse_start();
      repeat (80) @(negedge clk);
      #1;
      chk("gen_err_count", n_gerr - e0, 1);
      chk("gen_err_no_done", n_done - d0, 0);
      chk("gen_err_busy_low", int'(o_frame_busy), 0);
      chk("gen_err_no_vram", tot_en - en0, 0);
      chk("gen_err_queue_left", exp_q.size(), 0);
      m_dead = 1'b0;

      // Reset during packet 5 payload, then a clean restart.
      s0 = n_starts;
      push_frame();
      pulse_start();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (n_starts - s0 >= 5) break;
      end
      chk("reached_packet5", n_starts - s0, 5);
      repeat (50) @(negedge clk);
      #1 chk("packet5_reading", int'(o_vram_en), 1);
      rst = 1'b1;
      @(negedge clk);
      #1 chk("midframe_reset_outputs", any_out(), 0);
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      s0 = n_starts; d0 = n_done;
      push_frame();
      pulse_start();
      wait_done(seen);
      chk("frame4_done_seen", int'(seen), 1);
      repeat (20) @(negedge clk);
      #1;
      chk("frame4_starts", n_starts - s0, 12);
      chk("frame4_done_count", n_done - d0, 1);
      chk("frame4_queue_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
